symbol_serializer_10b: RTL and testbench
========================================

SYMBOL_SERIALIZER_10B -- requirements
Module: symbol_serializer_10b

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of 10-bit symbol buffer entries (power of two, >=2).
REQ-002 SHALL have parameter FILL_EN, default 1, enables K28.5 fill when the buffer is empty at a symbol boundary.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sym_i, input, 10, encoded symbol; bit 9 = a ... bit 0 = j, i.e. {6b code, 4b code}.
REQ-006 SHALL have port sym_valid_i, input, 1, sym_i is valid.
REQ-007 SHALL have port sym_ready_o, input-side handshake output, 1, buffer can accept a symbol.
REQ-008 SHALL have port tx_en_i, input, 1, serial transmission enable.
REQ-009 SHALL have port serial_o, output, 1, serial bit stream, bit a first.
REQ-010 SHALL have port sym_start_o, output, 1, high while serial_o carries bit a of any symbol.
REQ-011 SHALL have port underflow_o, output, 1, one-cycle pulse when a fill symbol replaces missing data.

Function
REQ-012 SHALL accept a symbol on every clk edge where sym_valid_i && sym_ready_o; sym_ready_o SHALL equal "buffer not full", registered.
REQ-013 SHALL buffer symbols in FIFO order; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-014 SHALL use a two-state FSM: IDLE, SHIFT.
REQ-015 SHALL define a load event as (IDLE && tx_en_i) or (SHIFT && bit_cnt == 9).
REQ-016 On a load event with tx_en_i high, SHALL load the shift register with the FIFO head (popping it), or, if empty and FILL_EN=1, with the next fill symbol; SHALL set bit_cnt to 0 and enter SHIFT.
REQ-017 On a load event in IDLE with empty FIFO and FILL_EN=0, SHALL remain in IDLE.
REQ-018 At bit_cnt == 9 with tx_en_i low, SHALL enter IDLE; deasserting tx_en_i mid-symbol SHALL NOT truncate the current symbol.
REQ-019 There SHALL be no write-to-load bypass: a symbol pushed in the cycle of a load event is not eligible for that load.
REQ-020 In SHIFT, serial_o SHALL present shift-register bit 9 and shift left by one each cycle; bit a appears one cycle after the load event.
REQ-021 In IDLE, serial_o SHALL be 0 and sym_start_o SHALL be 0.
REQ-022 Fill symbols SHALL alternate K28.5 RD- (10'b0011111010) then RD+ (10'b1100000101), starting with RD- after reset; the toggle SHALL advance only when fill is sent.
REQ-023 underflow_o SHALL pulse in the cycle after a fill load taken from SHIFT; a fill load from IDLE SHALL NOT pulse underflow_o.
REQ-024 With FILL_EN=0 and empty FIFO at bit_cnt == 9, SHALL enter IDLE and pulse underflow_o.
REQ-025 bit_cnt SHALL be 4 bits, counting 0..9 and wrapping to 0 only via a load event.

Reset
REQ-026 reset SHALL asynchronously clear: FSM to IDLE, bit_cnt 0, shift register 0, FIFO empty, fill toggle to RD-.
REQ-027 During and after reset: serial_o 0, sym_start_o 0, underflow_o 0, sym_ready_o 1.
REQ-028 reset asserted mid-symbol SHALL abort the symbol and discard buffered symbols; no partial symbol resumes.

Structure
REQ-029 Shared package pcie_phy_pkg SHALL hold SYM_W = 10, constants K28_5_RDN and K28_5_RDP, and the serializer state enum.
REQ-030 The buffer SHALL be a sub-module sym_fifo, parameterized by width and depth, exposing push, pop, full, empty, and head.
REQ-031 Total RTL SHALL be about 150-300 lines.

Verification
REQ-032 Reset release, tx_en_i=1, no data -> serial_o shows 0011111010 then 1100000101 repeatedly, sym_start_o every 10th cycle, underflow_o silent for the first fill and pulsing thereafter.
REQ-033 Push 10'h2AA, then 10'h155, before tx_en_i rises -> both sent back-to-back in order, bit 9 first, sym_start_o on the first bit of each, no underflow_o between them.
REQ-034 Push 3 symbols with FIFO_DEPTH=2 and tx_en_i=0 -> sym_ready_o falls after the 2nd; the 3rd is held by the source and sent after the first pop.
REQ-035 Drop tx_en_i at bit_cnt=4 -> the current symbol completes all 10 bits, then IDLE with serial_o 0.
REQ-036 Assert reset at bit_cnt=5 with 2 buffered -> outputs cleared immediately, sym_ready_o=1, and the next transmission starts with K28.5 RD-.
REQ-037 FILL_EN=0, single symbol 10'h3F0 -> transmitted, then IDLE with one underflow_o pulse.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_phy_pkg
// Description : Shared definitions for the 10-bit symbol serializer: symbol
//               width, K28.5 comma codes for both running disparities, the
//               last bit index of a symbol and the serializer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_phy_pkg;

    localparam int SYM_W = 10;

    // K28.5 comma, bit 9 (a) on the left, in its two disparity forms.
    localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

    // Bit counter value while the last bit (j) is on the line.
    localparam logic [3:0] LAST_BIT = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/symbol_serializer_10b_sym_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sym_fifo
// Description : Small synchronous FIFO for encoded symbols. Full and empty
//               are registered so downstream handshakes see clean flops.
//               A word written in a cycle is not visible at head until the
//               following cycle (no write-to-read bypass).
// Ports       : clk, reset (async, active high)
//               push/wdata - write request and data (ignored when full)
//               pop        - read request (ignored when empty)
//               full/empty - registered occupancy flags
//               head       - oldest stored word
// Revision    : 1.0 - initial release
// ============================================================================
module sym_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_nxt;

    assign w_push = push & ~r_full;
    assign w_pop  = pop & ~r_empty;

    // Simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_ONE;
            2'b01:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

    assign full  = r_full;
    assign empty = r_empty;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/symbol_serializer_10b.sv
`default_nettype none
// ============================================================================
// Module      : symbol_serializer_10b
// Description : Buffers 10-bit encoded symbols and shifts them out one bit
//               per clock, bit a (bit 9) first. When the buffer runs dry at
//               a symbol boundary it can insert K28.5 fill, alternating
//               RD- / RD+, and flags the gap on underflow_o.
// Ports       : clk, reset (async, active high)
//               sym_i/sym_valid_i/sym_ready_o - symbol input handshake
//               tx_en_i     - enables serial transmission
//               serial_o    - serial bit stream
//               sym_start_o - high while bit a of a symbol is on serial_o
//               underflow_o - one-cycle pulse when data was missing
// Revision    : 1.0 - initial release
// ============================================================================
module symbol_serializer_10b
    import pcie_phy_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter bit FILL_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SYM_W-1:0] sym_i,
    input  logic             sym_valid_i,
    output logic             sym_ready_o,
    input  logic             tx_en_i,
    output logic             serial_o,
    output logic             sym_start_o,
    output logic             underflow_o
);

    ser_state_t       r_state;
    logic [3:0]       r_bit_cnt;
    logic [SYM_W-1:0] r_shreg;
    logic             r_fill_rdp;     // next fill symbol is RD+ when set
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic [SYM_W-1:0] w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_load;

    assign w_push = sym_valid_i & ~w_full;
    assign w_load = ((r_state == ST_IDLE)  && tx_en_i) ||
                    ((r_state == ST_SHIFT) && (r_bit_cnt == LAST_BIT));
    assign w_pop  = w_load & tx_en_i & ~w_empty;

    sym_fifo #(
        .WIDTH (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (sym_i),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shreg     <= '0;
            r_fill_rdp  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= 1'b0;
            if (w_load && tx_en_i) begin
                if (!w_empty) begin
                    r_shreg   <= w_head;
                    r_bit_cnt <= 4'd0;
                    r_state   <= ST_SHIFT;
                end else if (FILL_EN) begin
                    r_shreg     <= r_fill_rdp ? K28_5_RDP : K28_5_RDN;
                    r_fill_rdp  <= ~r_fill_rdp;
                    r_bit_cnt   <= 4'd0;
                    r_state     <= ST_SHIFT;
                    // Fill at start-up from IDLE is expected, not a gap.
                    r_underflow <= (r_state == ST_SHIFT);
                end else begin
                    r_state     <= ST_IDLE;
                    r_underflow <= (r_state == ST_SHIFT);
                end
            end else if (r_state == ST_SHIFT) begin
                if (r_bit_cnt == LAST_BIT) begin
                    // Only reached with tx_en_i low: symbol is complete.
                    r_state <= ST_IDLE;
                end else begin
                    r_shreg   <= {r_shreg[SYM_W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    // Outputs are decoded straight from flops only.
    assign serial_o    = (r_state == ST_SHIFT) & r_shreg[SYM_W-1];
    assign sym_start_o = (r_state == ST_SHIFT) & (r_bit_cnt == 4'd0);
    assign underflow_o = r_underflow;
    assign sym_ready_o = ~w_full;

endmodule
`default_nettype wire

// File: tb/tb_symbol_serializer_10b.sv
`default_nettype none
// ============================================================================
// Module      : tb_symbol_serializer_10b
// Description : Directed self-checking bench for symbol_serializer_10b. One
//               instance uses fill (FILL_EN=1), a second has fill disabled.
//               Observed outputs are packed as {serial, start, underflow,
//               ready}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_symbol_serializer_10b;

    localparam logic [9:0] RDN = 10'b0011111010;
    localparam logic [9:0] RDP = 10'b1100000101;

    typedef struct {
        logic       tx_en;
        logic       valid;
        logic [9:0] sym;
        logic [3:0] exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [9:0] sym;
    logic       valid;
    logic       tx_en;
    logic       ready;
    logic       serial;
    logic       start;
    logic       uf;
    logic [9:0] sym0;
    logic       valid0;
    logic       tx_en0;
    logic       ready0;
    logic       serial0;
    logic       start0;
    logic       uf0;

    int n_vec = 0;
    int n_bad = 0;

    symbol_serializer_10b #(.FIFO_DEPTH(2), .FILL_EN(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .sym_i       (sym),
        .sym_valid_i (valid),
        .sym_ready_o (ready),
        .tx_en_i     (tx_en),
        .serial_o    (serial),
        .sym_start_o (start),
        .underflow_o (uf)
    );

    symbol_serializer_10b #(.FIFO_DEPTH(2), .FILL_EN(1'b0)) dut_nofill (
        .clk         (clk),
        .reset       (reset),
        .sym_i       (sym0),
        .sym_valid_i (valid0),
        .sym_ready_o (ready0),
        .tx_en_i     (tx_en0),
        .serial_o    (serial0),
        .sym_start_o (start0),
        .underflow_o (uf0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs(input int which);
        if (which == 0) return {serial0, start0, uf0, ready0};
        return {serial, start, uf, ready};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b ({serial,start,underflow,ready})",
                     name, act, exp);
        end
    endtask

    // Called in the cycle bit a is on the line; checks all ten bits and
    // returns in the cycle after bit j. Source valid drops after the first
    // edge; tx_en is dropped at bit index drop_at when drop_at >= 0.
    task automatic check_symbol(input int which, input logic [9:0] s, input logic uf_first,
                                input int drop_at, input string name);
        logic [3:0] o;
        for (int b = 0; b < 10; b++) begin
            o = outs(which);
            check($sformatf("%s bit%0d", name, b), {o[3:1], 1'b0},
                  {s[9-b], (b == 0), (b == 0) ? uf_first : 1'b0, 1'b0});
            if (b == drop_at) begin
                if (which == 0) tx_en0 = 1'b0;
                else            tx_en  = 1'b0;
            end
            step();
            if (which == 0) valid0 = 1'b0;
            else            valid  = 1'b0;
        end
    endtask

    initial begin
        vec_t       tbl [50];
        logic [9:0] blk_sym [5];
        logic       blk_uf [5];
        logic [9:0] s;
        int         b;
        int         k;

        // Free-running fill, a data symbol pushed mid-fill, then fill again:
        // the fill toggle must skip over the data symbol.
        blk_sym = '{RDN, RDP, RDN, 10'h0C5, RDP};
        blk_uf  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 50; i++) begin
            b = i / 10;
            k = i % 10;
            s = blk_sym[b];
            tbl[i].tx_en = 1'b1;
            tbl[i].valid = (i == 25);
            tbl[i].sym   = (i == 25) ? 10'h0C5 : 10'h000;
            tbl[i].exp   = {s[9-k], (k == 0), (k == 0) && blk_uf[b], 1'b1};
        end

        reset = 1'b1; tx_en = 1'b0; valid = 1'b0; sym = '0;
        tx_en0 = 1'b0; valid0 = 1'b0; sym0 = '0;
        step(); step();
        check("reset state", outs(1), 4'b0001);
        check("reset state nofill", outs(0), 4'b0001);
        reset = 1'b0;

        for (int i = 0; i < 50; i++) begin
            tx_en = tbl[i].tx_en;
            valid = tbl[i].valid;
            sym   = tbl[i].sym;
            step();
            check($sformatf("tbl[%0d]", i), outs(1), tbl[i].exp);
        end

        // Fresh start: three symbols into a two-entry buffer while idle.
        reset = 1'b1; tx_en = 1'b0; valid = 1'b0;
        step(); step();
        reset = 1'b0;
        sym = 10'h2AA; valid = 1'b1; step();
        check("push1 ready", outs(1), 4'b0001);
        sym = 10'h155; step();
        check("push2 full", outs(1), 4'b0000);
        sym = 10'h0F3; step(); step();
        check("third held", outs(1), 4'b0000);
        tx_en = 1'b1; step();
        check("ready after pop", {3'b000, ready}, 4'b0001);
        check_symbol(1, 10'h2AA, 1'b0, -1, "sym 2AA");
        check_symbol(1, 10'h155, 1'b0, -1, "sym 155");
        check_symbol(1, 10'h0F3, 1'b0, -1, "sym 0F3");
        // Fill after data underflows; tx_en drops at bit_cnt 4.
        check_symbol(1, RDN, 1'b1, 4, "fill drop");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle after drop %0d", i), outs(1), 4'b0001);
            step();
        end

        // Reset in the middle of a symbol with two entries buffered; the
        // fill toggle is at RD+ here, so RD- afterwards proves it reset.
        sym = 10'h3F8; valid = 1'b1; step();
        sym = 10'h01F; step();
        sym = 10'h333; tx_en = 1'b1; step();
        check("abort bit0", outs(1), 4'b1101);
        step();
        valid = 1'b0;
        repeat (4) step();
        check("abort bit5", outs(1), 4'b1000);
        reset = 1'b1;
        #1;
        check("async reset", outs(1), 4'b0001);
        step();
        reset = 1'b0;
        step();
        check_symbol(1, RDN, 1'b0, -1, "post-reset fill");
        check_symbol(1, RDP, 1'b1, -1, "post-reset fill2");
        tx_en = 1'b0;

        // Fill disabled: one symbol, then idle with a single underflow.
        sym0 = 10'h3F0; valid0 = 1'b1; step();
        valid0 = 1'b0;
        check("nofill push", outs(0), 4'b0001);
        tx_en0 = 1'b1; step();
        check_symbol(0, 10'h3F0, 1'b0, -1, "nofill 3F0");
        check("nofill underflow", outs(0), 4'b0011);
        step();
        check("nofill idle1", outs(0), 4'b0001);
        step();
        check("nofill idle2", outs(0), 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
